fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the instruction memory; drives its byte address every cycle and consumes its registered 1-cycle-latency read data.
- Owns the PC. Handles sequential fetch, stall-replay (the memory has no read enable) and branch/jump redirect.
- Detects a halt instruction, delivers (pc, instr, valid) to decode, and keeps an accepted-fetch counter.

---
 rtl/fetch_unit.sv | 108 ++++++++++
 tb/tb_fetch_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage feeding a 1-cycle-latency instruction memory.
//
// Owns the PC. It issues a byte address every cycle. When decode stalls, it
// re-issues the stalled address so the memory returns the same word again. It
// redirects on a taken branch or jump, stops on HALT_INSTR and counts accepted
// fetches.
//
// Ports
//   clk            clock, all state on posedge
//   rstn           asynchronous active-low reset
//   imem_addr      byte address presented to instruction memory
//   imem_rdata     word for the address presented in the previous cycle
//   stall          decode cannot take the current output
//   redirect_valid taken branch/jump from execute (highest priority)
//   redirect_pc    redirect target (low two bits ignored)
//   if_valid       if_pc/if_instr carry a real instruction
//   if_pc          address of if_instr
//   if_instr       fetched instruction (memory pass-through)
//   halted         fetch stopped on HALT_INSTR
//   fetch_count    number of accepted fetches (wraps)
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rstn,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_f_q, pc_f_d;    // next address to issue
  logic [31:0] pc_d_q, pc_d_d;    // address whose word is on imem_rdata
  logic        d_valid_q, d_valid_d;
  logic [31:0] count_q, count_d;

  logic        accept;
  logic [31:0] issue_pc;

  assign if_valid    = d_valid_q & (state_q == StRun);
  assign if_pc       = pc_d_q;
  assign if_instr    = imem_rdata;
  assign halted      = (state_q == StHalted);
  assign fetch_count = count_q;

  assign accept = if_valid & ~stall & ~redirect_valid;

  // A stalled valid word is replayed because the memory has no read enable.
  assign issue_pc  = (if_valid & stall) ? pc_d_q : pc_f_q;
  assign imem_addr = (state_q == StHalted) ? pc_f_q : issue_pc;

  always_comb begin
    state_d   = state_q;
    pc_f_d    = pc_f_q;
    pc_d_d    = pc_d_q;
    d_valid_d = d_valid_q;
    count_d   = count_q;

    if (accept) begin
      count_d = count_q + 32'd1;
    end

    if (redirect_valid) begin
      // The word fetched this cycle is killed; the target is issued next cycle.
      state_d   = StRun;
      pc_f_d    = redirect_pc & ~32'h3;
      pc_d_d    = imem_addr;
      d_valid_d = 1'b0;
    end else if (state_q == StHalted) begin
      // Frozen until a redirect or reset.
    end else if (accept && (imem_rdata == HALT_INSTR)) begin
      state_d   = StHalted;
      pc_f_d    = pc_d_q + 32'd4;
      d_valid_d = 1'b0;
    end else begin
      pc_d_d    = issue_pc;
      pc_f_d    = issue_pc + 32'd4;
      d_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StRun;
      pc_f_q    <= RESET_PC;
      pc_d_q    <= RESET_PC;
      d_valid_q <= 1'b0;
      count_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      pc_f_q    <= pc_f_d;
      pc_d_q    <= pc_d_d;
      d_valid_q <= d_valid_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// The memory model returns (addr>>2)^salt, with an optional halt word at
// halt_addr. The reference model views fetch as an instruction stream with
// four pieces of state: the visible pc, whether it is valid, whether fetch is
// halted, and the accept count.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] HALT_INSTR = 32'hFFFF_FFFF;

  logic        clk;
  logic        rstn;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        halted;
  logic [31:0] fetch_count;

  fetch_unit #(
    .RESET_PC  (RESET_PC),
    .HALT_INSTR(HALT_INSTR)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .if_valid      (if_valid),
    .if_pc         (if_pc),
    .if_instr      (if_instr),
    .halted        (halted),
    .fetch_count   (fetch_count)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Memory contents.
  logic [31:0] salt     = 32'd0;
  logic        halt_en  = 1'b0;
  logic [31:0] halt_addr = 32'd0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (halt_en && (a == halt_addr)) return HALT_INSTR;
    return (a >> 2) ^ salt;
  endfunction

  always @(posedge clk) imem_rdata <= mem_word(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stream-level reference model.
  logic        m_valid;
  logic [31:0] m_pc;      // visible pc when valid, otherwise the pc that appears next
  logic        m_halted;
  logic [31:0] m_count;

  task automatic model_reset();
    m_valid  = 1'b0;
    m_pc     = RESET_PC;
    m_halted = 1'b0;
    m_count  = 32'd0;
  endtask

  function automatic logic [31:0] exp_addr();
    if (m_halted) return m_pc;
    if (m_valid && !stall) return m_pc + 32'd4;
    return m_pc;
  endfunction

  task automatic model_step();
    if (redirect_valid) begin
      m_halted = 1'b0;
      m_valid  = 1'b0;
      m_pc     = {redirect_pc[31:2], 2'b00};
    end else if (m_halted) begin
    end else if (!m_valid) begin
      m_valid = 1'b1;
    end else if (!stall) begin
      m_count = m_count + 32'd1;
      if (mem_word(m_pc) == HALT_INSTR) begin
        m_halted = 1'b1;
        m_valid  = 1'b0;
      end
      m_pc = m_pc + 32'd4;
    end
  endtask

  // Cycle framing: every cycle starts just after a negedge.
  task automatic cyc_begin(input logic s, input logic rv, input logic [31:0] rpc);
    stall          = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  task automatic cyc_end();
    model_step();
    @(negedge clk);
  endtask

  task automatic go(input int n);
    for (int i = 0; i < n; i++) begin
      cyc_begin(1'b0, 1'b0, 32'd0);
      cyc_end();
    end
  endtask

  task automatic do_reset();
    cyc_begin(1'b0, 1'b0, 32'd0);
    rstn = 1'b0;
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    rstn = 1'b0;
    #1;
    n_vec++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", if_valid); end
    n_vec++; if (if_pc !== RESET_PC) begin n_bad++; $display("FAIL reset_pc got %h want %h", if_pc, RESET_PC); end
    n_vec++; if (halted !== 1'b0) begin n_bad++; $display("FAIL reset_halted got %b want 0", halted); end
    n_vec++; if (fetch_count !== 32'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", fetch_count); end
    n_vec++; if (imem_addr !== RESET_PC) begin n_bad++; $display("FAIL reset_addr got %h want %h", imem_addr, RESET_PC); end
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_sequential();
    do_reset();
    cyc_begin(1'b0, 1'b0, 32'd0);
    n_vec++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL seq_bubble got %b want 0", if_valid); end
    n_vec++; if (imem_addr !== 32'd0) begin n_bad++; $display("FAIL seq_first_addr got %h want 0", imem_addr); end
    cyc_end();
    for (int i = 0; i < 4; i++) begin
      cyc_begin(1'b0, 1'b0, 32'd0);
      n_vec++; if (if_valid !== 1'b1) begin n_bad++; $display("FAIL seq_valid[%0d] got %b want 1", i, if_valid); end
      n_vec++; if (if_pc !== 32'(4 * i)) begin n_bad++; $display("FAIL seq_pc[%0d] got %h want %h", i, if_pc, 32'(4 * i)); end
      n_vec++; if (if_instr !== 32'(i)) begin n_bad++; $display("FAIL seq_instr[%0d] got %h want %h", i, if_instr, 32'(i)); end
      n_vec++; if (imem_addr !== 32'(4 * i + 4)) begin n_bad++; $display("FAIL seq_addr[%0d] got %h want %h", i, imem_addr, 32'(4 * i + 4)); end
      cyc_end();
    end
    cyc_begin(1'b0, 1'b0, 32'd0);
    n_vec++; if (fetch_count !== 32'd4) begin n_bad++; $display("FAIL seq_count got %0d want 4", fetch_count); end
    cyc_end();
  endtask

  task automatic test_stall();
    do_reset();
    go(3);
    for (int i = 0; i < 3; i++) begin
      cyc_begin(1'b1, 1'b0, 32'd0);
      n_vec++; if (imem_addr !== 32'd8) begin n_bad++; $display("FAIL stall_addr[%0d] got %h want 8", i, imem_addr); end
      n_vec++; if (if_pc !== 32'd8 || if_valid !== 1'b1) begin n_bad++; $display("FAIL stall_pc[%0d] got %h/%b want 8/1", i, if_pc, if_valid); end
      n_vec++; if (if_instr !== 32'd2) begin n_bad++; $display("FAIL stall_instr[%0d] got %h want 2", i, if_instr); end
      n_vec++; if (fetch_count !== 32'd2) begin n_bad++; $display("FAIL stall_count[%0d] got %0d want 2", i, fetch_count); end
      cyc_end();
    end
    cyc_begin(1'b0, 1'b0, 32'd0);
    n_vec++; if (imem_addr !== 32'd12) begin n_bad++; $display("FAIL stall_release_addr got %h want c", imem_addr); end
    cyc_end();
    cyc_begin(1'b0, 1'b0, 32'd0);
    n_vec++; if (if_pc !== 32'd12) begin n_bad++; $display("FAIL stall_next_pc got %h want c", if_pc); end
    n_vec++; if (fetch_count !== 32'd3) begin n_bad++; $display("FAIL stall_next_count got %0d want 3", fetch_count); end
    cyc_end();
  endtask

  task automatic test_redirect();
    do_reset();
    go(2);
    cyc_begin(1'b0, 1'b1, 32'h0000_0103);
    n_vec++; if (if_pc !== 32'd4) begin n_bad++; $display("FAIL redir_src_pc got %h want 4", if_pc); end
    cyc_end();
    cyc_begin(1'b0, 1'b0, 32'd0);
    n_vec++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL redir_bubble got %b want 0", if_valid); end
    n_vec++; if (imem_addr !== 32'h100) begin n_bad++; $display("FAIL redir_addr got %h want 100", imem_addr); end
    n_vec++; if (fetch_count !== 32'd1) begin n_bad++; $display("FAIL redir_no_accept got %0d want 1", fetch_count); end
    cyc_end();
    cyc_begin(1'b0, 1'b0, 32'd0);
    n_vec++; if (if_valid !== 1'b1 || if_pc !== 32'h100) begin n_bad++; $display("FAIL redir_target got %h/%b want 100/1", if_pc, if_valid); end
    n_vec++; if (if_instr !== 32'h40) begin n_bad++; $display("FAIL redir_instr got %h want 40", if_instr); end
    cyc_end();
  endtask

  task automatic test_redirect_stall();
    do_reset();
    go(5);
    cyc_begin(1'b1, 1'b1, 32'h40);
    n_vec++; if (if_pc !== 32'd16) begin n_bad++; $display("FAIL rs_src_pc got %h want 10", if_pc); end
    cyc_end();
    cyc_begin(1'b0, 1'b0, 32'd0);
    n_vec++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL rs_dropped got %b want 0", if_valid); end
    n_vec++; if (imem_addr !== 32'h40) begin n_bad++; $display("FAIL rs_addr got %h want 40", imem_addr); end
    cyc_end();
    cyc_begin(1'b0, 1'b0, 32'd0);
    n_vec++; if (if_valid !== 1'b1 || if_pc !== 32'h40) begin n_bad++; $display("FAIL rs_target got %h/%b want 40/1", if_pc, if_valid); end
    n_vec++; if (fetch_count !== 32'd4) begin n_bad++; $display("FAIL rs_count got %0d want 4", fetch_count); end
    cyc_end();
  endtask

  task automatic test_halt();
    halt_en = 1'b1;
    halt_addr = 32'd12;
    do_reset();
    go(4);
    cyc_begin(1'b0, 1'b0, 32'd0);
    n_vec++; if (if_instr !== HALT_INSTR || if_pc !== 32'd12) begin n_bad++; $display("FAIL halt_word got %h@%h want ffffffff@c", if_instr, if_pc); end
    cyc_end();
    for (int i = 0; i < 3; i++) begin
      cyc_begin(1'(i), 1'b0, 32'd0);
      n_vec++; if (halted !== 1'b1 || if_valid !== 1'b0) begin n_bad++; $display("FAIL halt_state[%0d] got h=%b v=%b want h=1 v=0", i, halted, if_valid); end
      n_vec++; if (imem_addr !== 32'd16) begin n_bad++; $display("FAIL halt_addr[%0d] got %h want 10", i, imem_addr); end
      n_vec++; if (fetch_count !== 32'd4) begin n_bad++; $display("FAIL halt_count[%0d] got %0d want 4", i, fetch_count); end
      cyc_end();
    end
    cyc_begin(1'b0, 1'b1, 32'd0);
    cyc_end();
    cyc_begin(1'b0, 1'b0, 32'd0);
    n_vec++; if (halted !== 1'b0 || if_valid !== 1'b0) begin n_bad++; $display("FAIL halt_exit got h=%b v=%b want h=0 v=0", halted, if_valid); end
    cyc_end();
    cyc_begin(1'b0, 1'b0, 32'd0);
    n_vec++; if (if_valid !== 1'b1 || if_pc !== 32'd0) begin n_bad++; $display("FAIL halt_resume got %h/%b want 0/1", if_pc, if_valid); end
    cyc_end();
    halt_en = 1'b0;
  endtask

  task automatic test_wrap_async_reset();
    do_reset();
    go(1);
    cyc_begin(1'b0, 1'b1, 32'hFFFF_FFFC);
    cyc_end();
    go(1);
    cyc_begin(1'b0, 1'b0, 32'd0);
    n_vec++; if (if_pc !== 32'hFFFF_FFFC || if_instr !== 32'h3FFF_FFFF) begin n_bad++; $display("FAIL wrap_top got %h:%h want fffffffc:3fffffff", if_pc, if_instr); end
    n_vec++; if (imem_addr !== 32'd0) begin n_bad++; $display("FAIL wrap_addr got %h want 0", imem_addr); end
    cyc_end();
    cyc_begin(1'b1, 1'b0, 32'd0);
    n_vec++; if (if_valid !== 1'b1 || if_pc !== 32'd0) begin n_bad++; $display("FAIL wrap_pc got %h/%b want 0/1", if_pc, if_valid); end
    // Reset asserted mid-stall, between clock edges.
    #2 rstn = 1'b0;
    #1;
    n_vec++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL async_valid got %b want 0", if_valid); end
    n_vec++; if (fetch_count !== 32'd0) begin n_bad++; $display("FAIL async_count got %0d want 0", fetch_count); end
    n_vec++; if (imem_addr !== RESET_PC) begin n_bad++; $display("FAIL async_addr got %h want %h", imem_addr, RESET_PC); end
    n_vec++; if (if_pc !== RESET_PC || halted !== 1'b0) begin n_bad++; $display("FAIL async_pc got %h/%b want %h/0", if_pc, halted, RESET_PC); end
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
    go(1);
    cyc_begin(1'b0, 1'b0, 32'd0);
    n_vec++; if (if_valid !== 1'b1 || if_pc !== RESET_PC) begin n_bad++; $display("FAIL async_restart got %h/%b want %h/1", if_pc, if_valid, RESET_PC); end
    cyc_end();
  endtask

  task automatic test_random();
    logic        s, rv;
    logic [31:0] rpc;
    salt      = $urandom;
    halt_en   = 1'b1;
    halt_addr = {24'd0, 6'($urandom_range(2, 60)), 2'b00};
    do_reset();
    for (int i = 0; i < 800; i++) begin
      s   = ($urandom_range(0, 9) < 3);
      rv  = ($urandom_range(0, 99) < 6);
      rpc = ($urandom_range(0, 4) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                        : 32'($urandom_range(0, 255));
      cyc_begin(s, rv, rpc);
      n_vec++; if (if_valid !== m_valid) begin n_bad++; $display("FAIL rnd_valid[%0d] got %b want %b", i, if_valid, m_valid); end
      n_vec++; if (halted !== m_halted) begin n_bad++; $display("FAIL rnd_halted[%0d] got %b want %b", i, halted, m_halted); end
      n_vec++; if (fetch_count !== m_count) begin n_bad++; $display("FAIL rnd_count[%0d] got %0d want %0d", i, fetch_count, m_count); end
      n_vec++; if (imem_addr !== exp_addr()) begin n_bad++; $display("FAIL rnd_addr[%0d] got %h want %h", i, imem_addr, exp_addr()); end
      if (m_valid) begin
        n_vec++; if (if_pc !== m_pc) begin n_bad++; $display("FAIL rnd_pc[%0d] got %h want %h", i, if_pc, m_pc); end
        n_vec++; if (if_instr !== mem_word(m_pc)) begin n_bad++; $display("FAIL rnd_instr[%0d] got %h want %h", i, if_instr, mem_word(m_pc)); end
      end
      cyc_end();
    end
    halt_en = 1'b0;
    salt    = 32'd0;
  endtask

  initial begin
    rstn = 1'b0;
    stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    model_reset();
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_halt();
    test_wrap_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
